wide_add_sequencer: RTL and testbench
=====================================

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 Parameter: W, 32, word width of the shared adder datapath; the shared adder is fixed at 32 bits, so W SHALL be 32.
REQ-002 Parameter: WORDS, 4, number of W-bit passes per operation (operand width N = W*WORDS = 128).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  requester presents operands.
REQ-006 Port: in_ready  output  1  sequencer accepts operands this cycle.
REQ-007 Port: a  input  N  operand A, two's complement.
REQ-008 Port: b  input  N  operand B, two's complement.
REQ-009 Port: cin  input  1  carry into word 0.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer takes result.
REQ-012 Port: sum  output  N  registered result.
REQ-013 Port: cout  output  1  carry out of the final word.
REQ-014 Port: ovf  output  1  signed overflow of the N-bit addition.
REQ-015 Port: busy  output  1  high in states ADD and DONE.

Function
REQ-016 FSM states: IDLE, ADD, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, latch a, b and cin, clear the word counter, and go to ADD.
REQ-018 ADD: each edge presents word k (bits k*W+W-1:k*W) of the latched A/B plus the carry register to the shared adder.
REQ-019 ADD: each edge writes the adder Sum into sum word k and the adder Cout into the carry register; the counter increments.
REQ-020 Carry register SHALL be loaded with latched cin at accept; the carry into word k>0 SHALL be the carry out of word k-1.
REQ-021 After word WORDS-1 is written, go to DONE; out_valid SHALL rise exactly WORDS edges after the accept edge.
REQ-022 cout SHALL be the carry out of word WORDS-1.
REQ-023 ovf SHALL be (A[N-1]==B[N-1]) && (sum[N-1]!=A[N-1]).
REQ-024 DONE: out_valid=1; sum, cout and ovf SHALL be held stable until the out_valid&&out_ready edge, then go to IDLE.
REQ-025 in_ready SHALL be 0 in ADD and DONE; new operands are never accepted in the same cycle as result handoff.
REQ-026 in_valid, a, b and cin SHALL be ignored outside IDLE; operand changes after accept SHALL NOT affect the result.
REQ-027 Word counter SHALL be ceil(log2(WORDS)) bits wide and wrap to 0 on leaving ADD.
REQ-028 sum, cout and ovf SHALL retain the previous result in IDLE until overwritten by a new operation.

Reset
REQ-029 rst SHALL immediately force state IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, busy 0 and in_ready 1.
REQ-030 rst asserted mid-ADD or in DONE SHALL abort the operation with no result delivered; the first edge after deassertion behaves as IDLE.

Structure
REQ-031 Shared package SHALL hold the FSM state enum (2-bit encoding), W, WORDS, and the derived N and counter width.
REQ-032 One sub-module SHALL be instantiated: CarryBypass_Adder (32-bit A, B, Cin -> Sum, Cout), combinational.
REQ-033 All arithmetic SHALL go through this instance; no behavioural "+" in this block.

Verification
REQ-034 a=0x7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_..._0000, ovf=1, cout=0, out_valid 4 edges after accept.
REQ-035 a=all ones, b=1, cin=0 -> sum=0, cout=1, ovf=0 (carry ripples through all 4 words).
REQ-036 a=100, b=-200 (128-bit sign-extended), cin=0 -> sum=-100, cout=0, ovf=0.
REQ-037 Back-pressure: hold out_ready=0 for 3 cycles in DONE -> out_valid=1 and sum/cout/ovf stable, in_ready=0.
REQ-038 Back-pressure (cont.): in_valid held high throughout -> next operands accepted on the edge after in_ready returns to 1.
REQ-039 Reset at word 2: assert rst mid-ADD -> out_valid=0, in_ready=1, sum=0 with no clock edge.
REQ-040 Reset recovery (cont.): then a=-50, b=-100, cin=1 -> sum=-149, cout=1, ovf=0.
REQ-041 Operand change after accept: present a=50, b=100, cin=0, change a and b to 0 the edge after accept -> sum=150, cout=0, ovf=0.

Source files
------------

// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants and FSM encoding for the word-serial 128-bit adder.
package wide_add_sequencer_pkg;

    localparam int W     = 32;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Increment without an adder so the only arithmetic stays in the shared datapath.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        logic             k;
        r = '0;
        k = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            r[i] = c[i] ^ k;
            k    = k & c[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_carry_bypass_adder.sv
// 32-bit carry-bypass adder: 4-bit ripple blocks whose carry skips over a fully-propagating block.
module CarryBypass_Adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int BLK  = 4;
    localparam int NBLK = 32 / BLK;

    always_comb begin
        logic c;
        logic blk_cin;
        logic p;
        logic p_all;
        c       = cin;
        blk_cin = 1'b0;
        p       = 1'b0;
        p_all   = 1'b0;
        sum     = '0;
        for (int g = 0; g < NBLK; g++) begin
            blk_cin = c;
            p_all   = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                p              = a[g*BLK+i] ^ b[g*BLK+i];
                sum[g*BLK+i]   = p ^ c;
                c              = (a[g*BLK+i] & b[g*BLK+i]) | (p & c);
                p_all          = p_all & p;
            end
            if (p_all)
                c = blk_cin;
        end
        cout = c;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial N-bit adder: one W-bit pass per clock through a single shared 32-bit adder.
module wide_add_sequencer #(
    parameter int W     = 32,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*WORDS-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic               busy
);
    import wide_add_sequencer_pkg::*;

    localparam int NB = W * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [NB-1:0]   op_a, op_b;
    logic [W-1:0]    add_a, add_b, add_sum;
    logic            add_cout;
    logic            last_word;
    logic            accept;
    logic [CW-1:0]   cnt_nx;

    assign add_a     = op_a[cnt*W +: W];
    assign add_b     = op_b[cnt*W +: W];
    assign last_word = (cnt == CW'(WORDS-1));
    assign accept    = (state == IDLE) && in_valid;

    CarryBypass_Adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        logic k;
        cnt_nx = '0;
        k      = 1'b1;
        for (int i = 0; i < CW; i++) begin
            cnt_nx[i] = cnt[i] ^ k;
            k         = k & cnt[i];
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (last_word)
                    state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= cin;
            op_a  <= a;
            op_b  <= b;
        end else if (state == ADD) begin
            sum[cnt*W +: W] <= add_sum;
            carry           <= add_cout;
            cnt             <= last_word ? '0 : cnt_nx;
            // Final word carries the sign bit, so overflow and carry-out are captured here.
            if (last_word) begin
                cout <= add_cout;
                ovf  <= (op_a[NB-1] == op_b[NB-1]) && (add_sum[W-1] != op_a[NB-1]);
            end
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed-vector bench for wide_add_sequencer with hand-computed results.
module tb_wide_add_sequencer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_tests;
    int n_fail;

    wide_add_sequencer #(.W(32), .WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait for out_valid after an accept edge; returns the number of edges taken.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Full operation; clobber zeroes a/b right after the accept edge.
    task automatic run_op(input string tag, input logic [127:0] va, input logic [127:0] vb,
                          input logic vc, input logic clobber,
                          input logic [127:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (clobber) begin a = '0; b = '0; cin = 1'b0; end
        check({tag, ".busy"}, 128'(busy), 128'(1));
        wait_done(n);
        check({tag, ".lat"}, 128'(n), 128'(4));
        check({tag, ".sum"}, sum, es);
        check({tag, ".cout"}, 128'(cout), 128'(ec));
        check({tag, ".ovf"}, 128'(ovf), 128'(eo));
        handoff();
        check({tag, ".idle_rdy"}, 128'(in_ready), 128'(1));
        check({tag, ".hold_sum"}, sum, es);
    endtask

    initial begin
        int n;
        logic [127:0] s0;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #1;
        check("rst.in_ready", 128'(in_ready), 128'(1));
        check("rst.out_valid", 128'(out_valid), 128'(0));
        check("rst.busy", 128'(busy), 128'(0));
        check("rst.sum", sum, 128'd0);
        check("rst.cout", 128'(cout), 128'(0));
        check("rst.ovf", 128'(ovf), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        run_op("maxpos", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, 127'd0}, 1'b0, 1'b1);
        run_op("allones", {128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        run_op("neg", 128'd100, 128'd0 - 128'd200, 1'b0, 1'b0, 128'd0 - 128'd100, 1'b0, 1'b0);
        run_op("cin", 128'd0, 128'd0, 1'b1, 1'b0, 128'd1, 1'b0, 1'b0);
        run_op("w0carry", 128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, 128'h1_0000_0000, 1'b0, 1'b0);
        run_op("clobber", 128'd50, 128'd100, 1'b0, 1'b1, 128'd150, 1'b0, 1'b0);

        // Back-pressure with a queued requester holding in_valid high.
        @(negedge clk);
        a = 128'h0000_0001_FFFF_FFFF_0000_0002_8000_0000;
        b = 128'h0000_0002_0000_0001_0000_0003_8000_0000;
        cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 128'd5; b = 128'd7; cin = 1'b1;
        wait_done(n);
        check("bp.lat", 128'(n), 128'(4));
        s0 = 128'h0000_0004_0000_0000_0000_0006_0000_0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp.out_valid", 128'(out_valid), 128'(1));
            check("bp.in_ready", 128'(in_ready), 128'(0));
            check("bp.sum", sum, s0);
            check("bp.cout", 128'(cout), 128'(0));
            check("bp.ovf", 128'(ovf), 128'(0));
        end
        handoff();
        check("bp.ret_rdy", 128'(in_ready), 128'(1));
        check("bp.ret_ov", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.acc2", 128'(busy), 128'(1));
        wait_done(n);
        check("bp2.lat", 128'(n), 128'(4));
        check("bp2.sum", sum, 128'd13);
        handoff();

        // Reset in the middle of ADD, after two words are written.
        @(negedge clk);
        a = 128'd1000; b = 128'd2000; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("mid_rst.out_valid", 128'(out_valid), 128'(0));
        check("mid_rst.in_ready", 128'(in_ready), 128'(1));
        check("mid_rst.sum", sum, 128'd0);
        check("mid_rst.busy", 128'(busy), 128'(0));
        @(negedge clk); rst = 1'b0;
        run_op("recover", 128'd0 - 128'd50, 128'd0 - 128'd100, 1'b1, 1'b0,
               128'd0 - 128'd149, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
